// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared definitions for the reg_file_param register file.
//   state_t    - clear-sweep FSM states (IDLE, CLEAR)
//   DEF_*      - default parameter values used by reg_file_param and
//                reg_file_clr_seq
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_IMM_W  = 8;

endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: sequencer for the register-file clear sweep.
// On a rising edge with clr=1 in IDLE it enters CLEAR with the sweep counter
// at 1, then walks the counter up to DEPTH-1, requesting one entry clear per
// cycle. Entry 0 is never stored, so the sweep takes exactly DEPTH-1 cycles.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - start a sweep (sampled in IDLE only)
//   busy       - high in every CLEAR cycle
//   clr_done   - one-cycle pulse on the final sweep cycle
//   clr_en     - zero the entry at clr_addr on the next rising edge
//   clr_addr   - entry being cleared this cycle
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  // Last entry index; the terminal test stops here so the counter never wraps.
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          clr_done  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_en   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parameterised 2-read/1-write register file with entry 0
// hardwired to zero, an immediate substitute on read port 2, and a
// sequential clear sweep.
// Optional feature: define REG_FILE_BYPASS_EN to forward an accepted write
// (wd3) combinationally to any read port addressing the same entry.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (zeroes all entries)
//   we3, a3, wd3  - write port; ignored while the clear sweep runs
//   a1 -> rd1     - read port 1, zero when a1=0
//   a2, i2 -> rd2 - read port 2; a2=0 selects i2 zero-extended
//   clr           - start a clear sweep of entries 1..DEPTH-1
//   busy          - clear sweep running
//   clr_done      - pulse on the last sweep cycle
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IMM_W  = DEF_IMM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [IMM_W-1:0]  i2,
  input  logic              clr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Entry 0 is never written and resets to zero, so it folds to a constant.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;

  reg_file_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // Writes are dropped (not stalled) while the sweep runs.
  assign wr_ok = we3 && (a3 != '0) && !busy;

  // A write and a sweep clear never coincide: writes need IDLE, clears need CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (clr_en) mem[clr_addr] <= '0;
      if (wr_ok)  mem[a3]       <= wd3;
    end
  end

  always_comb begin
    rd1 = (a1 == '0) ? '0 : mem[a1];
    rd2 = (a2 == '0) ? DATA_W'(i2) : mem[a2];
`ifdef REG_FILE_BYPASS_EN
    // wr_ok implies a3 != 0, so a matching address is never entry 0.
    if (wr_ok && (a1 == a3)) rd1 = wd3;
    if (wr_ok && (a2 == a3)) rd2 = wd3;
`else
`endif
  end

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

  logic        clk;
  logic        rst;
  logic        we3, clr;
  logic [2:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic [7:0]  i2;
  logic [31:0] rd1, rd2;
  logic        busy, clr_done;

  logic        w_we3, w_clr;
  logic [3:0]  w_a1, w_a2, w_a3;
  logic [15:0] w_wd3;
  logic [7:0]  w_i2;
  logic [15:0] w_rd1, w_rd2;
  logic        w_busy, w_clr_done;

  int n_chk = 0;
  int n_fail = 0;

  reg_file_param dut (
    .clk(clk), .rst(rst), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .i2(i2), .clr(clr), .rd1(rd1), .rd2(rd2), .busy(busy), .clr_done(clr_done)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .IMM_W(8)) dut_w (
    .clk(clk), .rst(rst), .we3(w_we3), .a1(w_a1), .a2(w_a2), .a3(w_a3),
    .wd3(w_wd3), .i2(w_i2), .clr(w_clr), .rd1(w_rd1), .rd2(w_rd2),
    .busy(w_busy), .clr_done(w_clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain array of contents plus a queue of entries still
  // waiting to be cleared by the sweep.
  logic [31:0] m_mem [8];
  int          m_q [$];

  function automatic logic m_wr_ok();
    return we3 && (a3 != 3'd0) && (m_q.size() == 0) && !rst;
  endfunction

  function automatic logic [31:0] m_rd1();
    if (a1 == 3'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
    if (m_wr_ok() && a1 == a3) return wd3;
`endif
    return m_mem[a1];
  endfunction

  function automatic logic [31:0] m_rd2();
    if (a2 == 3'd0) return {24'd0, i2};
`ifdef REG_FILE_BYPASS_EN
    if (m_wr_ok() && a2 == a3) return wd3;
`endif
    return m_mem[a2];
  endfunction

  initial begin
    foreach (m_mem[i]) m_mem[i] = 32'd0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        foreach (m_mem[i]) m_mem[i] = 32'd0;
        m_q.delete();
      end else if (m_q.size() != 0) begin
        m_mem[m_q.pop_front()] = 32'd0;
      end else begin
        if (we3 && a3 != 3'd0) m_mem[a3] = wd3;
        if (clr) for (int i = 1; i < 8; i++) m_q.push_back(i);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("rd1", {32'd0, rd1}, {32'd0, m_rd1()});
      check("rd2", {32'd0, rd2}, {32'd0, m_rd2()});
      check("busy", {63'd0, busy}, {63'd0, m_q.size() != 0});
      check("clr_done", {63'd0, clr_done}, {63'd0, m_q.size() == 1});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we3 = 1'b1; a3 = a; wd3 = d;
    step();
    we3 = 1'b0;
  endtask

  int nb, dk;

  initial begin
    rst = 1'b0; we3 = 0; clr = 0; a1 = 3; a2 = 0; a3 = 0; wd3 = 0; i2 = 8'h3C;
    w_we3 = 0; w_clr = 0; w_a1 = 0; w_a2 = 0; w_a3 = 0; w_wd3 = 0; w_i2 = 0;
    #1 rst = 1'b1;
    step(); step();
    #2;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, clr_done}, 64'd0);
    check("reset_rd1", {32'd0, rd1}, 64'd0);
    check("reset_rd2_imm", {32'd0, rd2}, 64'h3C);
    rst = 1'b0;
    step();

    // Write then read back; a1=0 reads zero.
    a1 = 3'd5;
    we3 = 1'b1; a3 = 3'd5; wd3 = 32'hDEADBEEF;
    #2;
`ifdef REG_FILE_BYPASS_EN
    check("wr_same_cycle", {32'd0, rd1}, 64'hDEADBEEF);
`else
    check("wr_same_cycle", {32'd0, rd1}, 64'h0);
`endif
    step();
    we3 = 1'b0;
    #2 check("rd1_deadbeef", {32'd0, rd1}, 64'hDEADBEEF);
    a1 = 3'd0;
    #1 check("rd1_a0", {32'd0, rd1}, 64'h0);

    // Immediate on port 2 and a stored value on port 2.
    a2 = 3'd0; i2 = 8'hA5;
    #1 check("rd2_imm", {32'd0, rd2}, 64'h000000A5);
    step();
    wr(3'd3, 32'h12345678);
    a2 = 3'd3;
    #2 check("rd2_reg3", {32'd0, rd2}, 64'h12345678);
    wr(3'd0, 32'hFFFFFFFF);
    a1 = 3'd0;
    #1 check("write_a0_dropped", {32'd0, rd1}, 64'h0);

    // Same-cycle write/read of entry 4.
    wr(3'd4, 32'h11);
    a1 = 3'd4; we3 = 1'b1; a3 = 3'd4; wd3 = 32'h55;
    #2;
`ifdef REG_FILE_BYPASS_EN
    check("bypass_rd1", {32'd0, rd1}, 64'h55);
`else
    check("no_bypass_rd1", {32'd0, rd1}, 64'h11);
`endif
    step();
    we3 = 1'b0;
    #2 check("rd1_after_edge", {32'd0, rd1}, 64'h55);

    // Full sweep with a lost mid-sweep write.
    for (int i = 1; i < 8; i++) wr(3'(i), 32'h100 + 32'(i));
    clr = 1'b1; step(); clr = 1'b0;
    nb = 0; dk = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin we3 = 1'b1; a3 = 3'd2; wd3 = 32'hBAD; a1 = 3'd2; end
      else we3 = 1'b0;
      if (k == 1) a1 = 3'd7;
      #2;
      if (k == 1) check("unswept_rd1", {32'd0, rd1}, 64'h107);
      if (busy) nb++;
      if (clr_done) dk = k;
      step();
    end
    check("sweep_busy_cycles", 64'(nb), 64'd7);
    check("sweep_done_cycle", 64'(dk), 64'd7);
    for (int i = 1; i < 8; i++) begin
      a1 = 3'(i);
      #1 check("post_sweep_zero", {32'd0, rd1}, 64'h0);
    end
    step();

    // Reset during sweep cycle 3.
    for (int i = 1; i < 8; i++) wr(3'(i), 32'hA0 + 32'(i));
    clr = 1'b1; step(); clr = 1'b0;
    step(); step();
    a1 = 3'd7;
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, clr_done}, 64'd0);
    check("abort_rd1", {32'd0, rd1}, 64'h0);
    step();
    rst = 1'b0;
    step();
    #2 check("abort_idle", {63'd0, busy}, 64'd0);
    for (int i = 1; i < 8; i++) begin
      a1 = 3'(i);
      #1 check("abort_zero", {32'd0, rd1}, 64'h0);
    end
    step();

    // Randomized traffic checked by the per-cycle comparison.
    for (int n = 0; n < 400; n++) begin
      we3 = 1'($urandom_range(0, 1));
      a1 = 3'($urandom); a2 = 3'($urandom); a3 = 3'($urandom);
      wd3 = $urandom; i2 = 8'($urandom);
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
      rst = 1'b0;
    end
    we3 = 0; clr = 0;
    step();

    // Wide-address instance: DATA_W=16, ADDR_W=4.
    w_we3 = 1'b1; w_a3 = 4'd15; w_wd3 = 16'hBEEF;
    step();
    w_we3 = 1'b0; w_a1 = 4'd15;
    #2 check("w_rd1_beef", {48'd0, w_rd1}, 64'hBEEF);
    w_clr = 1'b1; step(); w_clr = 1'b0;
    nb = 0; dk = 0;
    for (int k = 1; k <= 20; k++) begin
      #2;
      if (w_busy) nb++;
      if (w_clr_done) dk = k;
      step();
    end
    check("w_sweep_cycles", 64'(nb), 64'd15);
    check("w_sweep_done", 64'(dk), 64'd15);
    #2 check("w_rd1_cleared", {48'd0, w_rd1}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and of all data ports.
REQ-002 Parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter IMM_W, default 8: immediate width, IMM_W <= DATA_W.
REQ-004 clk  input  1: single clock, all state updates on rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 we3  input  1: write enable for port 3.
REQ-007 a1, a2, a3  input  ADDR_W each: read port 1, read port 2, write port 3 addresses.
REQ-008 wd3  input  DATA_W: write data.
REQ-009 i2  input  IMM_W: immediate operand for port 2.
REQ-010 clr  input  1: request a sequential clear sweep of all registers.
REQ-011 rd1, rd2  output  DATA_W: read data.
REQ-012 busy  output  1: high while the clear sweep runs.
REQ-013 clr_done  output  1: one-cycle pulse on the last sweep cycle.

Function
REQ-014 Entry 0 is not stored and reads as zero; a write to a3=0 is discarded.
REQ-015 rd1 = register[a1], combinational, zero when a1=0.
REQ-016 rd2 = register[a2] when a2!=0; when a2=0, rd2 = i2 zero-extended to DATA_W.
REQ-017 A write is accepted when we3=1, a3!=0 and state is IDLE; register[a3] takes wd3 at the next rising edge.
REQ-018 FSM states IDLE and CLEAR; reset state IDLE.
REQ-019 IDLE -> CLEAR on a rising edge with clr=1; sweep counter loads 1.
REQ-020 In CLEAR, each cycle zeroes register[counter] and increments counter; at counter = DEPTH-1 that entry is zeroed, clr_done=1 for that cycle, and the next state is IDLE.
REQ-021 Sweep length is exactly DEPTH-1 cycles; busy=1 in every CLEAR cycle, 0 in IDLE.
REQ-022 In CLEAR, we3 is ignored (write lost, no stall) and clr is ignored.
REQ-023 Reads in CLEAR return current stored contents: swept entries read 0, unswept entries keep prior values.
REQ-024 clr and an accepted we3 in the same IDLE cycle: the write completes, then the sweep starts and later zeroes that entry.
REQ-025 Counter arithmetic is ADDR_W bits; the terminal test is counter == DEPTH-1, so no wrap is ever needed.

Reset
REQ-026 rst=1 immediately zeroes all entries 1..DEPTH-1 and the counter, forces IDLE, and drives busy=0 and clr_done=0, independent of clk.
REQ-027 rst during CLEAR aborts the sweep; after release the block is IDLE with all entries zero.
REQ-028 During reset, rd1 and rd2 follow REQ-015/016 with all entries zero.

Configuration
REQ-029 Macro REG_FILE_BYPASS_EN defined: if a write is accepted this cycle and a1==a3 (or a2==a3 with a2!=0), that read port returns wd3 combinationally.
REQ-030 REG_FILE_BYPASS_EN undefined: no forwarding, and reads return the old value until the edge.

Structure
REQ-031 Package reg_file_pkg holds the FSM state enum (IDLE, CLEAR) and default parameter constants.
REQ-032 One sub-module, reg_file_clr_seq, holds the FSM, counter, busy and clr_done, and gives the array a clear enable and clear address.

Verification
REQ-033 Write 0xDEADBEEF to a3=5, then a1=5 -> rd1=0xDEADBEEF next cycle; a1=0 -> rd1=0.
REQ-034 a2=0, i2=0xA5 -> rd2=0x000000A5; a2=3 holding 0x12345678 -> rd2=0x12345678.
REQ-035 Fill entries 1..7, pulse clr -> busy high 7 cycles, clr_done on 7th, all reads 0; we3 to entry 2 mid-sweep lost.
REQ-036 Assert rst on sweep cycle 3 -> busy=0 at once, all entries 0, IDLE after release.
REQ-037 With REG_FILE_BYPASS_EN, we3=1, a3=a1=4, wd3=0x55 -> rd1=0x55 same cycle; without the macro, rd1 keeps the old value until the edge.
REQ-038 DATA_W=16, ADDR_W=4: write 0xBEEF to entry 15 and read it back; the clear sweep takes 15 cycles.
